// File: rtl/processor_pkg.sv
// processor_pkg: opcode and funct constants, ALU op enum and funct decoder shared by the processor
package processor_pkg;
  localparam logic [5:0] OP_SW = 6'b000010;
  localparam logic [5:0] OP_LW = 6'b000100;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [2:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  function automatic alu_op_e alu_decode(input logic [5:0] funct);
    return funct == FN_ADD ? ALU_ADD :
           funct == FN_SUB ? ALU_SUB :
           funct == FN_AND ? ALU_AND :
           funct == FN_OR  ? ALU_OR  :
           funct == FN_SLT ? ALU_SLT : ALU_NOP;
  endfunction
endpackage

// File: rtl/processor_regfile.sv
// regfile: 32x32 register file, two async reads, one sync write, reg[i]=i on async active-low reset, reg[0] hardwired 0
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] da,
  output logic [31:0] db
);
  logic [31:0] r [32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) r[i] <= 32'(i);
    else if (we && wa != 5'd0) r[wa] <= wd;
  assign da = r[ra];
  assign db = r[rb];
endmodule

// File: rtl/processor.sv
// processor: single-cycle core executing externally supplied Inst (R-type ALU, sw, lw); ports clk, rst_n, Inst in, RD combinational result out
module processor import processor_pkg::*; #(
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst,
  output logic [31:0] RD
);
  localparam int K = $clog2(DMEM_WORDS);
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] a, b, alu, addr, mem_rd;
  logic is_r, is_sw, is_lw, we;
  logic [K-1:0] widx;
  alu_op_e alu_op;
  logic [31:0] dmem [DMEM_WORDS];
  assign op = Inst[31:26];
  assign rs = Inst[25:21];
  assign rt = Inst[20:16];
  assign rd = Inst[15:11];
  assign imm = Inst[15:0];
  assign is_r = op[0];
  assign is_sw = op == OP_SW;
  assign is_lw = op == OP_LW;
  assign alu_op = alu_decode(Inst[5:0]);
  regfile u_rf (
    .clk(clk), .rst_n(rst_n), .ra(rs), .rb(rt),
    .we(we), .wa(is_r ? rd : rt), .wd(is_r ? alu : mem_rd),
    .da(a), .db(b)
  );
  always_comb begin
    alu = alu_op == ALU_ADD ? a + b :
          alu_op == ALU_SUB ? a - b :
          alu_op == ALU_AND ? a & b :
          alu_op == ALU_OR  ? a | b :
          alu_op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} : 32'b0;
  end
  // word index keeps only address bits [K+1:2], so accesses wrap modulo memory size
  assign addr = a + {{16{imm[15]}}, imm};
  assign widx = K'(addr >> 2);
  assign mem_rd = dmem[widx];
  assign we = (is_r && alu_op != ALU_NOP) || is_lw;
  assign RD = is_r ? alu : is_sw ? b : is_lw ? mem_rd : 32'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'b0;
    else if (is_sw) dmem[widx] <= b;
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed vectors with scoreboard queue checking RD of the processor
module tb_processor;
  logic clk = 0;
  logic rst_n = 0;
  logic [31:0] Inst = 0;
  logic [31:0] RD;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t q[$];

  processor #(.DMEM_WORDS(32)) dut (.clk(clk), .rst_n(rst_n), .Inst(Inst), .RD(RD));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                        input logic [5:0] f, input logic [5:0] op = 6'b000001);
    return {op, s, t, d, 5'b0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] exp, input string nm);
    @(posedge clk);
    #1;
    Inst = ins;
    q.push_back('{exp, nm});
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    Inst = 32'h0;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (RD !== e.exp) begin
        miscompares++;
        $display("FAIL %s: RD=%h expected %h", e.name, RD, e.exp);
      end
    end
  end

  initial begin
    apply(enc_r(1, 2, 11, 6'b100101), 32'd3, "reset_or_r1_r2");
    apply(enc_i(6'b000100, 31, 12, 16'h0), 32'd0, "reset_lw_dmem7");
    release_reset();
    apply(32'h04430820, 32'd5, "add_r1");
    apply(32'h0C432022, 32'hFFFFFFFF, "sub_r4");
    apply(32'h14432824, 32'd2, "and_r5");
    apply(32'h1C433025, 32'd3, "or_r6");
    apply(enc_r(4, 2, 10, 6'b101010), 32'd1, "slt_neg_lt_pos");
    apply(enc_r(2, 4, 12, 6'b101010), 32'd0, "slt_pos_lt_neg");
    apply(32'h08080000, 32'd8, "sw_r8");
    apply(32'h10670000, 32'd8, "lw_addr3_word0");
    apply(enc_r(7, 0, 11, 6'b100101), 32'd8, "read_r7_after_lw");
    apply(enc_r(1, 0, 11, 6'b100101), 32'd5, "read_r1_after_add");
    apply(enc_r(2, 3, 0, 6'b100000), 32'd5, "add_to_r0");
    apply(enc_r(0, 0, 9, 6'b100101), 32'd0, "or_r0_r0");
    apply(32'hFC000000, 32'd0, "unknown_op");
    apply(enc_r(4, 4, 13, 6'b100000), 32'hFFFFFFFE, "add_wrap");
    apply(enc_i(6'b000010, 3, 6, 16'hFFFC), 32'd3, "sw_neg_offset");
    apply(enc_i(6'b000100, 0, 14, 16'd124), 32'd3, "lw_word31");
    apply(enc_i(6'b000100, 0, 15, 16'd128), 32'd8, "lw_addr_wrap");
    apply(enc_r(1, 2, 16, 6'b100000, 6'b000011), 32'd7, "rtype_op3_add");
    apply(enc_r(1, 2, 17, 6'b000000), 32'd0, "nop_funct");
    apply(enc_r(17, 0, 18, 6'b100101), 32'd17, "r17_unchanged");
    apply(enc_r(19, 19, 19, 6'b100000), 32'd38, "raw_same_cycle");
    apply(enc_r(19, 0, 20, 6'b100101), 32'd38, "r19_written");
    @(posedge clk);
    #2;
    rst_n = 0;
    Inst = 32'h0;
    apply(enc_r(1, 0, 11, 6'b100101), 32'd1, "midreset_r1");
    apply(enc_i(6'b000100, 0, 12, 16'h0), 32'd0, "midreset_dmem0");
    apply(enc_i(6'b000100, 0, 12, 16'd124), 32'd0, "midreset_dmem31");
    apply(32'h04430820, 32'd5, "add_during_reset");
    release_reset();
    apply(enc_r(1, 0, 11, 6'b100101), 32'd1, "r1_after_reset");
    apply(enc_i(6'b000100, 0, 12, 16'h0), 32'd0, "dmem0_after_reset");
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter: DMEM_WORDS, default 32, number of 32-bit data-memory words (power of two, 2..256).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Inst  input  32  instruction executed this cycle, supplied externally; no internal PC or instruction memory.
REQ-005 Port: RD  output  32  combinational result bus for the current Inst.

Function
REQ-006 Single-cycle, non-pipelined; each Inst is decoded combinationally and commits at the next rising clk edge.
REQ-007 Fields: op=Inst[31:26], rs=Inst[25:21], rt=Inst[20:16], rd=Inst[15:11], funct=Inst[5:0], imm=Inst[15:0].
REQ-008 R-type when op[0]=1 (e.g. 000001, 000011, 000101, 000111); the ALU operation is selected by funct only.
REQ-009 R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0); all other funct values are NOPs.
REQ-010 Add and sub wrap modulo 2^32; overflow is ignored and never trapped.
REQ-011 R-type writes reg[rd] = ALU(reg[rs], reg[rt]); RD = ALU result.
REQ-012 op=000010 is sw: address = reg[rs] + signext(imm); dmem[address[k+1:2]] = reg[rt], where k = log2(DMEM_WORDS); RD = reg[rt].
REQ-013 op=000100 is lw: same address computation; reg[rt] = dmem[address[k+1:2]]; RD = that data.
REQ-014 Address bits [1:0] and bits above k+1 are ignored, so addresses wrap modulo memory size; no alignment fault is raised.
REQ-015 All other op values are NOPs: no register or memory write, and RD = 0.
REQ-016 Register file: 32 x 32-bit, two combinational read ports and one write port; reg[0] always reads 0 and writes to it are discarded.
REQ-017 Reads see the pre-edge value; a write and a read of the same register in one cycle return the old value to that instruction.
REQ-018 RD changes combinationally with Inst and with state; it is valid for sampling before the rising edge.

Reset
REQ-019 While rst_n=0, and immediately on its falling edge: reg[i] = i for i = 1..31, reg[0] = 0, and every dmem word = 0.
REQ-020 No state changes while rst_n=0; the first commit occurs at the first rising clk edge after rst_n deasserts.
REQ-021 RD carries no reset value of its own; after reset it reflects the current Inst evaluated on the reset state.
REQ-022 Reset asserted mid-operation overrides any pending write.

Structure
REQ-023 A shared package holds the opcode constants (OP_SW=000010, OP_LW=000100), the funct constants, and the ALU operation enum.
REQ-024 The block is built from one sub-module, regfile (32x32, 2R1W, async reset); the ALU, decode and data memory are inline.

Verification
REQ-025 After reset, add $1,$2,$3 (0x04430820) -> RD=5; after the edge reg[1]=5.
REQ-026 sub $4,$2,$3 (0x0C432022) -> RD=0xFFFFFFFF; and $5,$2,$3 (0x14432824) -> RD=2; or $6,$2,$3 (0x1C433025) -> RD=3.
REQ-027 sw $8,0($0) (0x08080000) -> RD=8 and dmem[0]=8; then lw $7,0($3) (0x10670000) -> address 3 maps to word 0, RD=8, and reg[7]=8.
REQ-028 add $0,$2,$3 -> reg[0] remains 0; a following or $9,$0,$0 -> RD=0.
REQ-029 Unknown op 0x3F / funct 0x00 -> RD=0 with no state change; asserting rst_n low mid-sequence -> reg[1] returns to 1 and dmem[0] returns to 0.
REQ-030 slt $10,$4,$2 after the sub above -> RD=1 (signed -1 < 2).
